// File: rtl/cpu_nic_pkg.sv
// Shared definitions for the processor-to-ring NIC: register map, status/packet bit positions.
// Register and packet bits are numbered [0:63] with bit 0 as the leftmost (most significant) bit.
package cpu_nic_pkg;

  typedef enum logic [1:0] {
    NIC_IN_BUF   = 2'd0,
    NIC_IN_STAT  = 2'd1,
    NIC_OUT_BUF  = 2'd2,
    NIC_OUT_STAT = 2'd3
  } nic_reg_e;

  localparam int NIC_STAT_BIT   = 63;
  // Packet bit 0 carries the virtual channel; bits 1 onward follow the ring packet format.
  localparam int NIC_PKT_VC_BIT = 0;

  function automatic logic [0:NIC_STAT_BIT] nic_status(input logic flag);
    logic [0:NIC_STAT_BIT] s;
    s               = '0;
    s[NIC_STAT_BIT] = flag;
    return s;
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry channel buffer with a full flag; load takes priority over clear.
module nic_chan_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [0:DATA_WIDTH-1] data_i,
  output logic [0:DATA_WIDTH-1] data_o,
  output logic                  full_o
);

  logic [0:DATA_WIDTH-1] buf_q, buf_d;
  logic                  full_q, full_d;

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (load_i) begin
      buf_d  = data_i;
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign data_o = buf_q;
  assign full_o = full_q;

endmodule

// File: rtl/cpu_nic.sv
// NIC between the processor data-memory port and the ring router: register decode, load data register,
// one input and one output channel buffer. Optional macro NIC_POLARITY_EN gates injection on VC polarity.
module cpu_nic
  import cpu_nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  input  logic                  net_polarity
);

  nic_reg_e              sel;
  logic                  rd_en, wr_en;
  logic                  in_full, out_full;
  logic                  in_load, in_clr, out_load, out_clr;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;
  logic [0:DATA_WIDTH-1] d_out_q, d_out_d;

  assign sel   = nic_reg_e'(addr[1:0]);
  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // No bypass: an arriving packet is only accepted into an empty buffer.
  assign in_load  = net_si & ~in_full;
  assign in_clr   = rd_en & (sel == NIC_IN_BUF);
  assign out_load = wr_en & (sel == NIC_OUT_BUF) & ~out_full;
  assign out_clr  = net_so & net_ro;

  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (in_load),
    .clr_i  (in_clr),
    .data_i (net_di),
    .data_o (in_buf),
    .full_o (in_full)
  );

  nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (out_load),
    .clr_i  (out_clr),
    .data_i (d_in),
    .data_o (out_buf),
    .full_o (out_full)
  );

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      unique case (sel)
        NIC_IN_BUF:   d_out_d = in_buf;
        NIC_IN_STAT:  d_out_d = nic_status(in_full);
        NIC_OUT_BUF:  d_out_d = '0;
        NIC_OUT_STAT: d_out_d = nic_status(out_full);
        default:      d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_do = out_buf;
  assign net_ri = ~in_full;

`ifdef NIC_POLARITY_EN
  assign net_so = out_full & (out_buf[NIC_PKT_VC_BIT] == net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign net_so          = out_full;
`endif

endmodule

// File: tb/tb_cpu_nic.sv
// Randomized and directed bench for cpu_nic against a transaction-level reference model.
module tb_cpu_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0, nicWrEn = 1'b0;
  logic        net_so, net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_si = 1'b0, net_ri;
  logic [63:0] net_di = '0;
  logic        net_polarity = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register values held as plain numbers; bit 63 of the map is numeric bit 0.
  bit          m_in_full, m_out_full;
  logic [63:0] m_in_buf, m_out_buf, m_dout;

  cpu_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_so();
`ifdef NIC_POLARITY_EN
    // Packet bit 0 (leftmost) is the VC bit; it must match the router's polarity.
    return m_out_full && ((m_out_buf >> 63) == 64'(net_polarity));
`else
    return m_out_full;
`endif
  endfunction

  task automatic check_all();
    check("net_so", 64'(net_so), 64'(model_so()));
    check("net_ri", 64'(net_ri), 64'(!m_in_full));
    check("net_do", net_do, m_out_buf);
    check("d_out", d_out, m_dout);
  endtask

  task automatic model_clear();
    m_in_full = 0; m_out_full = 0;
    m_in_buf = '0; m_out_buf = '0; m_dout = '0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the model, check.
  task automatic cycle(input bit en, input bit wr, input logic [1:0] a, input logic [63:0] din,
                       input bit ro, input bit si, input logic [63:0] di, input bit pol);
    bit sent, accepted, read_in;
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_si = si; net_di = di; net_polarity = pol;

    sent     = model_so() && ro;
    accepted = si && !m_in_full;
    read_in  = en && !wr && (a == 2'd0);
    if (en && !wr) begin
      if (a == 2'd0)      m_dout = m_in_buf;
      else if (a == 2'd1) m_dout = m_in_full ? 64'd1 : 64'd0;
      else if (a == 2'd2) m_dout = 64'd0;
      else                m_dout = m_out_full ? 64'd1 : 64'd0;
    end
    if (accepted) begin
      m_in_full = 1; m_in_buf = di;
    end else if (read_in) begin
      m_in_full = 0;
    end
    if (en && wr && a == 2'd2 && !m_out_full) begin
      m_out_full = 1; m_out_buf = din;
    end else if (sent) begin
      m_out_full = 0;
    end

    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit ro);
    cycle(0, 0, 2'd0, 64'd0, ro, 0, 64'd0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1, 0, a, 64'd0, 0, 0, 64'd0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("rst_net_so", 64'(net_so), 64'd0);
    check("rst_net_ri", 64'(net_ri), 64'd1);
    check("rst_net_do", net_do, 64'd0);
    check("rst_d_out", d_out, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
  endtask

  localparam logic [63:0] PKT_OUT = 64'h0123456789ABCDEF;
  localparam logic [63:0] PKT_A   = 64'h0000_1111_2222_3330;
  localparam logic [63:0] PKT_B   = 64'h0555_6666_7777_8888;
  localparam logic [63:0] PKT_IN  = 64'hDEADBEEF00000001;

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_all();

    // Dirty the state, then reset mid-run and read both status registers.
    cycle(1, 1, 2'd2, PKT_A, 0, 1, PKT_IN, 0);
    async_reset();
    rd(2'd1);
    check("stat_in_after_rst", d_out, 64'd0);
    rd(2'd3);
    check("stat_out_after_rst", d_out, 64'd0);

    // Store then inject with the router ready.
    cycle(1, 1, 2'd2, PKT_OUT, 1, 0, 64'd0, 0);
    check("so_after_store", 64'(net_so), 64'd1);
    check("do_after_store", net_do, PKT_OUT);
    idle(1);
    check("so_after_xfer", 64'(net_so), 64'd0);
    rd(2'd3);
    check("out_stat_empty", d_out, 64'd0);

    // Back-pressure: second store while full is dropped.
    cycle(1, 1, 2'd2, PKT_A, 0, 0, 64'd0, 0);
    cycle(1, 1, 2'd2, PKT_B, 0, 0, 64'd0, 0);
    check("do_holds_A", net_do, PKT_A);
    rd(2'd3);
    check("out_stat_full", d_out, 64'd1);
    idle(1);
    rd(2'd3);
    check("out_stat_after_A", d_out, 64'd0);

    // Ingress: accept, status, read out, empty again.
    cycle(0, 0, 2'd0, 64'd0, 0, 1, PKT_IN, 0);
    check("ri_low_when_full", 64'(net_ri), 64'd0);
    rd(2'd1);
    check("in_stat_full", d_out, 64'd1);
    rd(2'd0);
    check("in_buf_read", d_out, PKT_IN);
    check("ri_high_after_read", 64'(net_ri), 64'd1);
    rd(2'd1);
    check("in_stat_empty", d_out, 64'd0);
    rd(2'd2);
    check("read_out_buf_zero", d_out, 64'd0);

`ifdef NIC_POLARITY_EN
    // VC bit set: injection only while net_polarity = 1.
    cycle(1, 1, 2'd2, 64'h8000_0000_0000_00AA, 1, 0, 64'd0, 0);
    check("pol0_no_so", 64'(net_so), 64'd0);
    cycle(0, 0, 2'd0, 64'd0, 1, 0, 64'd0, 0);
    check("pol0_still_full", 64'(dut.out_full), 64'd1);
    cycle(0, 0, 2'd0, 64'd0, 0, 0, 64'd0, 1);
    check("pol1_so", 64'(net_so), 64'd1);
    cycle(0, 0, 2'd0, 64'd0, 1, 0, 64'd0, 1);
    check("pol1_sent", 64'(net_so), 64'd0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ((i % 200) == 199) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
              {$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
              {$urandom, $urandom}, $urandom_range(0, 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_nic.md
# cpu_nic

Network interface controller between the pipelined processor's data-memory port and its ring router. It exposes four 64-bit memory-mapped registers to the processor and runs a one-entry valid/ready buffer in each direction toward the router. Processor stores to the output channel register become packets injected into the ring. Packets ejected from the ring are held in the input channel register until the processor reads them.

## Interface
- Parameters:
- DATA_WIDTH, 64, packet and register width
- ADDR_WIDTH, 2, register select width
- Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- addr  input  ADDR_WIDTH  register select, from processor data address low bits
- d_in  input  DATA_WIDTH  processor store data
- d_out  output  DATA_WIDTH  processor load data, registered
- nicEn  input  1  register access enable
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn
- net_so  output  1  packet valid toward router
- net_ro  input  1  router ready to accept
- net_do  output  DATA_WIDTH  packet toward router
- net_si  input  1  packet valid from router
- net_ri  output  1  NIC ready to accept
- net_di  input  DATA_WIDTH  packet from router
- net_polarity  input  1  router even/odd cycle polarity

## Operation
- Register map, bit order [0:63], status flag in bit 63, all other status bits read 0:
  - 0: input channel buffer (read)
  - 1: input status (read)
  - 2: output channel buffer (write)
  - 3: output status (read)
- Reads of 2 and writes to 0, 1 or 3 are ignored. A read of 2 returns 0.
- Input side: net_ri = ~in_full. When net_si & net_ri, latch net_di and set in_full.
- Processor read of address 0 returns the buffer and clears in_full at the same edge.
- Reading address 0 while empty returns stale data and leaves in_full 0.
- Output side: a write to address 2 loads d_in and sets out_full only if out_full = 0 before the edge. A write while full is dropped.
- net_do = output buffer. net_so is defined under Configuration.
- When net_so & net_ro at an edge, the packet transfers and out_full clears.
- Simultaneous transfer and processor write while full: transfer happens, write is dropped.
- Simultaneous input arrival and processor read of address 0 cannot occur, because net_ri is low while full. No bypass path exists.

## Timing
- Reset (async, reset = 0): in_full = 0, out_full = 0, both buffers = 0, d_out = 0. Consequently net_so = 0, net_ri = 1, net_do = 0.
- Load latency: d_out is valid the cycle after nicEn & ~nicWrEn. d_out holds its value when there is no read.
- Store latency: out_full rises at the edge of the write. net_so can assert in the next cycle.
- Ingress: in_full is set at the accept edge. Input status reads 1 from the next read onward.
- Sustained throughput: one packet per two cycles per direction, because of the single entry with no bypass.
- Status reads reflect state before the edge, so same-edge updates are not visible.
- Reset asserted mid-transfer discards both buffers. No handshake completes while reset = 0.

## Configuration
- NIC_POLARITY_EN defined: net_so = out_full & (out_buf[0] == net_polarity). Packet bit 0 is the virtual-channel bit, and injection waits for matching polarity.
- NIC_POLARITY_EN undefined: net_so = out_full. The net_polarity port remains but is ignored.

## Structure
- Shared package holds:
  - register address constants (NIC_IN_BUF = 0, NIC_IN_STAT = 1, NIC_OUT_BUF = 2, NIC_OUT_STAT = 3)
  - status bit index (63)
  - packet field positions: bit 0 VC, bits 1 onward as defined by the ring packet format
- Sub-module nic_chan_buf: one-entry buffer with full flag, load/clear strobes and async active-low reset. It is instantiated once for input and once for output.
- Top level holds address decode, the d_out register and the polarity gate.

## Test plan
- Reset with reset = 0 mid-run, then read addresses 1 and 3: d_out = 0 for both; net_ri = 1, net_so = 0.
- Write 0x0123456789ABCDEF to address 2 with net_ro = 1 and (polarity off) net_so high next cycle: net_do = 0x0123456789ABCDEF, out_full clears after one handshake edge, and address 3 reads 0.
- Hold net_ro = 0, then write A followed by B to address 2: net_do stays A, so B is dropped. Raise net_ro: A is sent and address 3 reads 0.
- Drive net_si with 0xDEADBEEF00000001: net_ri drops next cycle and address 1 reads 1. A read of address 0 returns the packet one cycle later, then net_ri = 1 and address 1 reads 0.
- With NIC_POLARITY_EN, write a packet with bit 0 = 1 while toggling net_polarity: net_so asserts only in cycles with net_polarity = 1, and transfer occurs only there.
